// File: rtl/rast_tri_arbiter.sv
// Two-source triangle arbiter feeding the bounding-box stage.
// Round-robin on contention, one registered output slot with full-throughput
// handoff, synchronous flush, and saturating per-source handoff counters.
module rast_tri_arbiter #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned RADIX  = 10,
  parameter int unsigned VERTS  = 3,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3,
  parameter int unsigned NREQ   = 2,
  parameter int unsigned CNTW   = 16
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic signed [NREQ-1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_i,
  input  logic        [NREQ-1:0][COLORS-1:0][SIGFIG-1:0]    color_i,
  input  logic        [NREQ-1:0]                            valid_i,
  output logic        [NREQ-1:0]                            ready_o,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]     tri_o,
  output logic        [COLORS-1:0][SIGFIG-1:0]              color_o,
  output logic                                              valid_o,
  output logic                                              src_o,
  input  logic                                              ready_i,
  input  logic                                              flush_i,
  output logic        [NREQ-1:0][CNTW-1:0]                  count_o,
  output logic                                              idle_o
);

  // Data is passed through untouched, so the fixed-point split is irrelevant here.
  localparam int unsigned FRAC_BITS = RADIX;

  logic            ptr;      // index of the last granted source
  logic [NREQ-1:0] grant;
  logic            space;
  logic            accept;
  logic            sel;
  logic            handoff;

  // Output slot can take a new triangle when empty or draining, unless flushed.
  assign space   = (!valid_o || ready_i) && !flush_i;
  assign handoff = valid_o && ready_i && !flush_i;

  // Grant: lone requester wins; on a tie the source that did not win last time.
  always_comb begin
    grant = '0;
    case (valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  assign ready_o = grant & {NREQ{space && rst_n}};
  assign accept  = |ready_o;
  assign sel     = ready_o[1];
  assign idle_o  = !valid_o && !(|valid_i);

  // Output slot, source tag and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      src_o   <= 1'b0;
      tri_o   <= '0;
      color_o <= '0;
      ptr     <= 1'b1;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (accept) begin
      valid_o <= 1'b1;
      src_o   <= sel;
      tri_o   <= tri_i[sel];
      color_o <= color_i[sel];
      ptr     <= sel;
    end else if (handoff) begin
      valid_o <= 1'b0;
    end
  end

  // Per-source handoff counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (handoff && (int'(src_o) == i) && (count_o[i] != {CNTW{1'b1}})) begin
          count_o[i] <= count_o[i] + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rast_tri_arbiter.sv
// Directed bench for rast_tri_arbiter: reset, single source, contention,
// halt, flush, counter saturation and asynchronous reset.
module tb_rast_tri_arbiter;

  localparam int unsigned SIGFIG = 24;
  localparam int unsigned VERTS  = 3;
  localparam int unsigned AXIS   = 3;
  localparam int unsigned COLORS = 3;
  localparam int unsigned CNTW   = 4;

  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] col_t;

  logic                 clk;
  logic                 rst_n;
  logic signed [1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_i;
  logic [1:0][COLORS-1:0][SIGFIG-1:0] color_i;
  logic [1:0]           valid_i;
  logic [1:0]           ready_o;
  tri_t                 tri_o;
  col_t                 color_o;
  logic                 valid_o;
  logic                 src_o;
  logic                 ready_i;
  logic                 flush_i;
  logic [1:0][CNTW-1:0] count_o;
  logic                 idle_o;

  int checks;
  int failures;

  rast_tri_arbiter #(
    .SIGFIG(SIGFIG), .RADIX(10), .VERTS(VERTS), .AXIS(AXIS),
    .COLORS(COLORS), .NREQ(2), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tri_i(tri_i), .color_i(color_i),
    .valid_i(valid_i), .ready_o(ready_o), .tri_o(tri_o), .color_o(color_o),
    .valid_o(valid_o), .src_o(src_o), .ready_i(ready_i), .flush_i(flush_i),
    .count_o(count_o), .idle_o(idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, partly negative vertex patterns per seed.
  function automatic tri_t mk_tri(input int seed);
    tri_t t;
    for (int v = 0; v < int'(VERTS); v++)
      for (int a = 0; a < int'(AXIS); a++)
        t[v][a] = SIGFIG'((a == 1) ? -(seed * 100 + v * 10 + a) : (seed * 100 + v * 10 + a));
    return t;
  endfunction

  function automatic col_t mk_col(input int seed);
    col_t c;
    for (int k = 0; k < int'(COLORS); k++) c[k] = SIGFIG'(seed * 7 + k + 1);
    return c;
  endfunction

  // Enter reset at posedge+1, release one cycle later at posedge+1.
  task automatic do_reset();
    rst_n   = 1'b0;
    valid_i = 2'b00;
    ready_i = 1'b1;
    flush_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 2'b11; ready_i = 1'b1; flush_i = 1'b0;
    tri_i[0] = mk_tri(1); tri_i[1] = mk_tri(2);
    color_i[0] = mk_col(1); color_i[1] = mk_col(2);
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", valid_o); failures++; end
    checks++; if (src_o !== 1'b0) begin $display("FAIL reset_src got=%b exp=0", src_o); failures++; end
    checks++; if (tri_o !== '0) begin $display("FAIL reset_tri got=%h exp=0", tri_o); failures++; end
    checks++; if (color_o !== '0) begin $display("FAIL reset_color got=%h exp=0", color_o); failures++; end
    checks++; if (count_o !== '0) begin $display("FAIL reset_count got=%h exp=0", count_o); failures++; end
    checks++; if (ready_o !== 2'b00) begin $display("FAIL reset_ready got=%b exp=00", ready_o); failures++; end
    checks++; if (idle_o !== 1'b0) begin $display("FAIL reset_idle_req got=%b exp=0", idle_o); failures++; end
    valid_i = 2'b00; #1;
    checks++; if (idle_o !== 1'b1) begin $display("FAIL reset_idle got=%b exp=1", idle_o); failures++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    ready_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      valid_i = 2'b01; tri_i[0] = mk_tri(k); color_i[0] = mk_col(k);
      #1;
      checks++; if (ready_o !== 2'b01) begin $display("FAIL single_ready k=%0d got=%b exp=01", k, ready_o); failures++; end
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b1 || src_o !== 1'b0 || tri_o !== mk_tri(k) || color_o !== mk_col(k)) begin
        $display("FAIL single_out k=%0d got valid=%b src=%b tri=%h exp valid=1 src=0 tri=%h", k, valid_o, src_o, tri_o, mk_tri(k));
        failures++;
      end
    end
    valid_i = 2'b00;
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin $display("FAIL single_drain got=%b exp=0", valid_o); failures++; end
    checks++; if (count_o[0] !== 4'd5 || count_o[1] !== 4'd0) begin $display("FAIL single_count got=%0d,%0d exp=5,0", count_o[0], count_o[1]); failures++; end
    checks++; if (idle_o !== 1'b1) begin $display("FAIL single_idle got=%b exp=1", idle_o); failures++; end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy;
    do_reset();
    ready_i = 1'b1; valid_i = 2'b11;
    tri_i[0] = mk_tri(10); tri_i[1] = mk_tri(20);
    color_i[0] = mk_col(10); color_i[1] = mk_col(20);
    for (int k = 0; k < 6; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (ready_o !== exp_rdy) begin $display("FAIL cont_ready k=%0d got=%b exp=%b", k, ready_o, exp_rdy); failures++; end
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b1 || src_o !== 1'(k % 2) || tri_o !== mk_tri((k % 2 == 0) ? 10 : 20)) begin
        $display("FAIL cont_out k=%0d got valid=%b src=%b exp valid=1 src=%0d", k, valid_o, src_o, k % 2);
        failures++;
      end
    end
    valid_i = 2'b00;
    @(posedge clk); #1;
    checks++; if (count_o[0] !== 4'd3 || count_o[1] !== 4'd3) begin $display("FAIL cont_count got=%0d,%0d exp=3,3", count_o[0], count_o[1]); failures++; end
  endtask

  task automatic test_halt();
    do_reset();
    ready_i = 1'b1; valid_i = 2'b01; tri_i[0] = mk_tri(30); color_i[0] = mk_col(30);
    @(posedge clk); #1;
    valid_i = 2'b10; tri_i[1] = mk_tri(31); color_i[1] = mk_col(31); ready_i = 1'b0;
    tri_i[0] = mk_tri(99);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (ready_o !== 2'b00) begin $display("FAIL halt_ready k=%0d got=%b exp=00", k, ready_o); failures++; end
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b1 || src_o !== 1'b0 || tri_o !== mk_tri(30) || color_o !== mk_col(30)) begin
        $display("FAIL halt_hold k=%0d got valid=%b src=%b tri=%h exp tri=%h", k, valid_o, src_o, tri_o, mk_tri(30));
        failures++;
      end
    end
    checks++; if (count_o[0] !== 4'd0) begin $display("FAIL halt_nocount got=%0d exp=0", count_o[0]); failures++; end
    ready_i = 1'b1; #1;
    checks++; if (ready_o !== 2'b10) begin $display("FAIL halt_release_ready got=%b exp=10", ready_o); failures++; end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b1 || src_o !== 1'b1 || tri_o !== mk_tri(31) || color_o !== mk_col(31)) begin
      $display("FAIL halt_nobubble got valid=%b src=%b tri=%h exp valid=1 src=1 tri=%h", valid_o, src_o, tri_o, mk_tri(31));
      failures++;
    end
    checks++; if (count_o[0] !== 4'd1) begin $display("FAIL halt_handoff got=%0d exp=1", count_o[0]); failures++; end
    valid_i = 2'b00;
    @(posedge clk); #1;
    checks++; if (count_o[1] !== 4'd1 || valid_o !== 1'b0) begin $display("FAIL halt_drain got cnt1=%0d valid=%b exp 1,0", count_o[1], valid_o); failures++; end
  endtask

  task automatic test_flush();
    do_reset();
    ready_i = 1'b1; valid_i = 2'b01; tri_i[0] = mk_tri(40);
    @(posedge clk); #1;
    ready_i = 1'b0; flush_i = 1'b1; tri_i[0] = mk_tri(41);
    #1;
    checks++; if (ready_o !== 2'b00) begin $display("FAIL flush_ready got=%b exp=00", ready_o); failures++; end
    @(posedge clk); #1;
    flush_i = 1'b0; ready_i = 1'b1;
    checks++; if (valid_o !== 1'b0) begin $display("FAIL flush_valid got=%b exp=0", valid_o); failures++; end
    checks++; if (count_o !== '0) begin $display("FAIL flush_count got=%h exp=0", count_o); failures++; end
    valid_i = 2'b11; #1;
    checks++; if (ready_o !== 2'b10) begin $display("FAIL flush_ptr got=%b exp=10", ready_o); failures++; end
    valid_i = 2'b00;
  endtask

  task automatic test_saturation();
    do_reset();
    ready_i = 1'b1; valid_i = 2'b10; tri_i[1] = mk_tri(50);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
    end
    valid_i = 2'b00;
    @(posedge clk); #1;
    checks++; if (count_o[1] !== 4'd15) begin $display("FAIL sat_count1 got=%0d exp=15", count_o[1]); failures++; end
    checks++; if (count_o[0] !== 4'd0) begin $display("FAIL sat_count0 got=%0d exp=0", count_o[0]); failures++; end
  endtask

  task automatic test_async_reset();
    do_reset();
    ready_i = 1'b1; valid_i = 2'b01; tri_i[0] = mk_tri(60);
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (valid_o !== 1'b1 || count_o[0] !== 4'd2) begin $display("FAIL arst_pre got valid=%b cnt=%0d exp 1,2", valid_o, count_o[0]); failures++; end
    #2; rst_n = 1'b0; valid_i = 2'b11; #1;
    checks++; if (valid_o !== 1'b0) begin $display("FAIL arst_valid got=%b exp=0", valid_o); failures++; end
    checks++; if (count_o !== '0) begin $display("FAIL arst_count got=%h exp=0", count_o); failures++; end
    checks++; if (ready_o !== 2'b00) begin $display("FAIL arst_ready got=%b exp=00", ready_o); failures++; end
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    checks++; if (ready_o !== 2'b01) begin $display("FAIL arst_tie got=%b exp=01", ready_o); failures++; end
    @(posedge clk); #1;
    checks++; if (src_o !== 1'b0 || count_o !== '0) begin $display("FAIL arst_first got src=%b cnt=%h exp 0,0", src_o, count_o); failures++; end
    valid_i = 2'b00;
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_single();
    test_contention();
    test_halt();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
